min_search_sequencer: RTL and testbench

//  Sequences one minimum search over NUM_CAND candidates through the 4-lane MIN pipeline
//  (MIN1 -> MIN2 ...). Issues one 4-candidate group per cycle and tags the last group with

---
 rtl/min_search_sequencer.sv | 140 ++++++++++++++
 tb/tb_min_search_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/min_search_sequencer.sv
// rtl/min_search_sequencer.sv - issues NUM_CAND/4 four-lane groups and reduces lane minima to one global best
// Optional input stall is compiled in when MINSEQ_STALL_EN is defined.
module min_search_sequencer #(
    parameter int IDX_W    = 16,
    parameter int VAL_W    = 14,
    parameter int NUM_CAND = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 issue_valid,
    output logic [IDX_W-1:0]     issue_base,
    output logic                 issue_trigger,
    input  logic                 res_valid,
    input  logic                 res_trigger,
    input  logic [4*IDX_W-1:0]   res_index,
    input  logic [4*VAL_W-1:0]   res_value,
    output logic [IDX_W-1:0]     best_index,
    output logic [VAL_W-1:0]     best_value
`ifdef MINSEQ_STALL_EN
    ,
    input  logic                 stall
`endif
);

    localparam logic [IDX_W-1:0] LAST_BASE = IDX_W'(NUM_CAND - 4);
    localparam logic [IDX_W-1:0] STEP      = IDX_W'(4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic               busy_n, done_n, issue_valid_n, issue_trigger_n;
    logic [IDX_W-1:0]   issue_base_n, best_index_n;
    logic [VAL_W-1:0]   best_value_n;
    logic [IDX_W-1:0]   win_index;
    logic [VAL_W-1:0]   win_value;
    logic               stall_act;

`ifdef MINSEQ_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    // Strict compare so equal values keep the lowest lane.
    always_comb begin
        win_index = res_index[0 +: IDX_W];
        win_value = res_value[0 +: VAL_W];
        for (int k = 1; k < 4; k++) begin
            if (res_value[k*VAL_W +: VAL_W] < win_value) begin
                win_index = res_index[k*IDX_W +: IDX_W];
                win_value = res_value[k*VAL_W +: VAL_W];
            end
        end
    end

    always_comb begin
        state_n         = state;
        busy_n          = busy;
        done_n          = 1'b0;
        issue_valid_n   = 1'b0;
        issue_base_n    = issue_base;
        issue_trigger_n = issue_trigger;
        best_index_n    = best_index;
        best_value_n    = best_value;

        if ((state == ISSUE || state == DRAIN) && res_valid && (win_value < best_value)) begin
            best_index_n = win_index;
            best_value_n = win_value;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    state_n         = ISSUE;
                    busy_n          = 1'b1;
                    issue_valid_n   = 1'b1;
                    issue_base_n    = '0;
                    issue_trigger_n = (LAST_BASE == '0);
                    best_index_n    = '0;
                    best_value_n    = '1;
                end
            end
            ISSUE: begin
                // issue_base always names the group most recently issued, so a
                // stall simply withholds the next advance.
                if (issue_valid && issue_trigger) begin
                    state_n         = DRAIN;
                    issue_trigger_n = 1'b0;
                end else if (stall_act) begin
                    issue_valid_n   = 1'b0;
                end else begin
                    issue_valid_n   = 1'b1;
                    issue_base_n    = issue_base + STEP;
                    issue_trigger_n = ((issue_base + STEP) == LAST_BASE);
                end
            end
            DRAIN: begin
                if (res_valid && res_trigger) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            issue_valid   <= 1'b0;
            issue_base    <= '0;
            issue_trigger <= 1'b0;
            best_index    <= '0;
            best_value    <= '1;
        end else begin
            state         <= state_n;
            busy          <= busy_n;
            done          <= done_n;
            issue_valid   <= issue_valid_n;
            issue_base    <= issue_base_n;
            issue_trigger <= issue_trigger_n;
            best_index    <= best_index_n;
            best_value    <= best_value_n;
        end
    end

endmodule

// File: tb/tb_min_search_sequencer.sv
// tb/tb_min_search_sequencer.sv - directed bench for min_search_sequencer with NUM_CAND=16
// The stall scenario is included when MINSEQ_STALL_EN is defined.
module tb_min_search_sequencer;

    localparam int IDX_W = 16;
    localparam int VAL_W = 14;
    localparam int NC    = 16;

    logic               clk = 1'b0;
    logic               rst, start, res_valid, res_trigger;
    logic [4*IDX_W-1:0] res_index;
    logic [4*VAL_W-1:0] res_value;
    logic               busy, done, issue_valid, issue_trigger;
    logic [IDX_W-1:0]   issue_base, best_index;
    logic [VAL_W-1:0]   best_value;
`ifdef MINSEQ_STALL_EN
    logic               stall = 1'b0;
`endif

    always #5 clk = ~clk;

    min_search_sequencer #(.IDX_W(IDX_W), .VAL_W(VAL_W), .NUM_CAND(NC)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .issue_valid(issue_valid),
        .issue_base(issue_base), .issue_trigger(issue_trigger),
        .res_valid(res_valid), .res_trigger(res_trigger),
        .res_index(res_index), .res_value(res_value),
        .best_index(best_index), .best_value(best_value)
`ifdef MINSEQ_STALL_EN
        , .stall(stall)
`endif
    );

    typedef struct {bit v; bit t; int base;} grp_t;
    grp_t pipe[4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, n_issue = 0, trig_cnt = 0, trig_base = -1;
    int done_cnt = 0, done_cyc = -1, res_last_cyc = -100;
    int issue_log[$];
    int pipe_delay = 2;
    int vmode = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [VAL_W-1:0] cost(input int idx);
        case (vmode)
            0:       return VAL_W'(idx ^ 5);
            1:       return VAL_W'(7);
            default: return (idx == 15) ? VAL_W'(1) : VAL_W'(100 + idx);
        endcase
    endfunction

    // Pipeline model: result for the group issued in cycle C returns in cycle C+pipe_delay.
    initial begin
        res_valid = 1'b0; res_trigger = 1'b0; res_index = '0; res_value = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0].v = issue_valid; pipe[0].t = issue_trigger; pipe[0].base = int'(issue_base);
            if (issue_valid) begin
                n_issue++;
                issue_log.push_back(int'(issue_base));
                if (issue_trigger) begin trig_cnt++; trig_base = int'(issue_base); end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            res_valid   = pipe[pipe_delay].v;
            res_trigger = pipe[pipe_delay].t;
            for (int k = 0; k < 4; k++) begin
                res_index[k*IDX_W +: IDX_W] = IDX_W'(pipe[pipe_delay].base + k);
                res_value[k*VAL_W +: VAL_W] = cost(pipe[pipe_delay].base + k);
            end
            if (res_valid && res_trigger) res_last_cyc = cyc;
        end
    end

    task automatic clear_stats();
        n_issue = 0; trig_cnt = 0; trig_base = -1; done_cnt = 0;
        done_cyc = -1; res_last_cyc = -100; issue_log.delete();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check({tag, "_done_seen"}, done, 1);
    endtask

    task automatic check_result(input string tag, input int exp_idx, input int exp_val);
        check({tag, "_best_index"}, best_index, exp_idx);
        check({tag, "_best_value"}, best_value, exp_val);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_done_latency"}, done_cyc - res_last_cyc, 1);
        check({tag, "_issue_count"}, n_issue, 4);
        check({tag, "_trigger_count"}, trig_cnt, 1);
        check({tag, "_trigger_base"}, trig_base, 12);
        if (issue_log.size() == 4)
            for (int i = 0; i < 4; i++) check({tag, "_issue_base_seq"}, issue_log[i], 4 * i);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_done_count"}, done_cnt, 1);
    endtask

    task automatic do_search(input string tag, input int vm, input int dly,
                             input int exp_idx, input int exp_val);
        vmode = vm; pipe_delay = dly;
        clear_stats();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_first_issue"}, issue_valid, 1);
        check({tag, "_first_base"}, issue_base, 0);
        check({tag, "_best_cleared"}, best_value, 14'h3FFF);
        wait_done(tag);
        check_result(tag, exp_idx, exp_val);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_base", issue_base, 0);
        check("rst_issue_trigger", issue_trigger, 0);
        check("rst_best_index", best_index, 0);
        check("rst_best_value", best_value, 14'h3FFF);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", busy, 0);

        do_search("basic", 0, 2, 5, 0);
        do_search("ties", 1, 2, 0, 7);
        do_search("last_lane", 2, 1, 15, 1);

        // Abort mid-ISSUE; in-flight results then land while idle.
        vmode = 0; pipe_delay = 2; clear_stats();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_issue_valid", issue_valid, 0);
        repeat (5) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle_best_value", best_value, 14'h3FFF);
        check("abort_idle_best_index", best_index, 0);
        check("abort_issue_count", n_issue, 2);

        // start pulses while busy and during DONE must not restart.
        vmode = 0; pipe_delay = 2; clear_stats();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            start = (i % 2 == 0);
        end
        check("restart_done_seen", done, 1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("restart_done_start_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("restart_issue_count", n_issue, 4);
        check("restart_idle_valid", issue_valid, 0);
        check("restart_best_index", best_index, 5);

`ifdef MINSEQ_STALL_EN
        vmode = 0; pipe_delay = 2; clear_stats();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        check("stall_second_base", issue_base, 4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_no_issue", issue_valid, 0);
            check("stall_base_hold", issue_base, 4);
        end
        stall = 1'b0;
        wait_done("stall");
        check_result("stall", 5, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
